// File: rtl/ring_frame_rotator.sv
// ---------------------------------------------------------------------------
// ring_frame_rotator
//
// Collects a frame of three symbols into a ring of registers a, b, c, then
// presents the ring state to the downstream side rot_count+1 times: the
// loaded state followed by rot_count single-step rotations
// (a <= c, b <= a, c <= b). The next frame is accepted only after the last
// state has been handed off.
//
// Handshake semantics (both sides): a transfer happens on a rising clock
// edge where valid and ready are both high. A producer holding valid keeps
// its payload stable until the transfer. in_ready is driven purely from
// state and rst and never looks at in_valid. out_valid is driven purely
// from state and rst and never looks at out_ready.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-low reset
//   in_valid   upstream symbol valid
//   in_ready   block accepts a symbol this cycle (FILL and out of reset)
//   in_data    upstream symbol, W bits
//   rot_count  rotations for the frame, sampled with the third symbol
//   out_valid  ring state presented on out_a/out_b/out_c (ROTATE)
//   out_ready  downstream accepts the presented state
//   out_a/b/c  current ring registers a, b, c
//   out_last   high with out_valid on the final state of a frame
//   busy       high while the FSM is in ROTATE (state visibility)
// ---------------------------------------------------------------------------
module ring_frame_rotator #(
   parameter int W  = 2,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic [CW-1:0] rot_count,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_a,
   output logic [W-1:0]  out_b,
   output logic [W-1:0]  out_c,
   output logic          out_last,
   output logic          busy
);

   typedef enum logic {
      FILL   = 1'b0,
      ROTATE = 1'b1
   } state_t;

   // Reset contents of the ring; the casts truncate to W bits.
   localparam logic [W-1:0] RST_A = W'(1);
   localparam logic [W-1:0] RST_B = W'(2);
   localparam logic [W-1:0] RST_C = W'(3);

   state_t        state, state_nx;
   logic [1:0]    idx, idx_nx;
   logic [CW-1:0] rem, rem_nx;
   logic [W-1:0]  a, b, c;
   logic [W-1:0]  a_nx, b_nx, c_nx;
   logic          in_fire, out_fire;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= FILL;
      end else begin
         state <= state_nx;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         idx <= 2'd0;
         rem <= '0;
         a   <= RST_A;
         b   <= RST_B;
         c   <= RST_C;
      end else begin
         idx <= idx_nx;
         rem <= rem_nx;
         a   <= a_nx;
         b   <= b_nx;
         c   <= c_nx;
      end
   end

   // Next-state and outputs. Gating the handshake outputs with rst keeps
   // them low for the whole reset window, including before the first edge
   // and when reset lands in the middle of a rotation.
   always_comb begin
      state_nx  = state;
      idx_nx    = idx;
      rem_nx    = rem;
      a_nx      = a;
      b_nx      = b;
      c_nx      = c;
      in_ready  = (state == FILL) && rst;
      out_valid = (state == ROTATE) && rst;
      busy      = (state == ROTATE) && rst;
      out_last  = out_valid && (rem == '0);
      in_fire   = in_valid && in_ready;
      out_fire  = out_valid && out_ready;

      case (state)
         FILL: begin
            if (in_fire) begin
               case (idx)
                  2'd0: begin
                     a_nx   = in_data;
                     idx_nx = 2'd1;
                  end
                  2'd1: begin
                     b_nx   = in_data;
                     idx_nx = 2'd2;
                  end
                  2'd2: begin
                     c_nx     = in_data;
                     idx_nx   = 2'd0;
                     rem_nx   = rot_count;
                     state_nx = ROTATE;
                  end
                  default: begin
                     // Unreachable index; fall back to the start of a frame.
                     idx_nx = 2'd0;
                  end
               endcase
            end
         end

         ROTATE: begin
            if (out_fire) begin
               if (rem != '0) begin
                  a_nx   = c;
                  b_nx   = a;
                  c_nx   = b;
                  rem_nx = rem - 1'b1;
               end else begin
                  // Last state handed off; ring keeps its final contents.
                  idx_nx   = 2'd0;
                  state_nx = FILL;
               end
            end
         end

         default: begin
            state_nx = FILL;
         end
      endcase
   end

   assign out_a = a;
   assign out_b = b;
   assign out_c = c;

endmodule

// File: tb/tb_ring_frame_rotator.sv
// ---------------------------------------------------------------------------
// tb_ring_frame_rotator
//
// Directed bench for ring_frame_rotator (W=2, CW=4). Inputs change 1 ns
// after each rising edge; a monitor samples on the falling edge, pops the
// expected {a,b,c,last} tuple from exp_q on every output handshake and
// checks that a stalled state stays put while out_ready is low.
// ---------------------------------------------------------------------------
module tb_ring_frame_rotator;

   localparam int W  = 2;
   localparam int CW = 4;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [CW-1:0] rot_count;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_a, out_b, out_c;
   logic          out_last;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [6:0] exp_q[$];

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   ring_frame_rotator #(.W(W), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .rot_count (rot_count),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_c     (out_c),
      .out_last  (out_last),
      .busy      (busy)
   );

   // ---------------------------------------------------------------- check
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] pk(input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] c, input logic l);
      return {a, b, c, l};
   endfunction

   function automatic logic [5:0] ring3(input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] c);
      return {a, b, c};
   endfunction

   // -------------------------------------------------------------- monitor
   logic       hold_v = 1'b0;
   logic [6:0] hold_val;

   always @(negedge clk) begin
      if (hold_v && out_valid)
         chk("stall_stable", pk(out_a, out_b, out_c, out_last), hold_val);
      hold_v   = out_valid && !out_ready;
      hold_val = pk(out_a, out_b, out_c, out_last);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", pk(out_a, out_b, out_c, out_last), 7'h0);
         end else begin
            chk("output_tuple", pk(out_a, out_b, out_c, out_last), exp_q.pop_front());
         end
      end
   end

   // -------------------------------------------------------------- drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_sym(input logic [1:0] d, input logic [3:0] rc);
      int n = 0;
      in_valid  = 1'b1;
      in_data   = d;
      rot_count = rc;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [1:0] d0, input logic [1:0] d1,
                             input logic [1:0] d2, input logic [3:0] rc);
      send_sym(d0, 4'd0);
      send_sym(d1, 4'd0);
      send_sym(d2, rc);
   endtask

   // toggle: flip out_ready every cycle; noisy_in: keep in_valid high with
   // random in_data until only the final state is left.
   task automatic drain(input bit toggle, input bit noisy_in);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         if (toggle) out_ready = ~out_ready;
         if (noisy_in) begin
            in_valid = (exp_q.size() > 1);
            in_data  = 2'($urandom_range(0, 3));
         end
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout", exp_q.size(), 32'd0);
         exp_q.delete();
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
   endtask

   task automatic push_rotations(input logic [1:0] a0, input logic [1:0] b0,
                                 input logic [1:0] c0, input int rc);
      logic [1:0] a = a0, b = b0, c = c0, t;
      for (int i = 0; i <= rc; i++) begin
         exp_q.push_back(pk(a, b, c, i == rc));
         t = c; c = b; b = a; a = t;
      end
   endtask

   // ------------------------------------------------------------- sequence
   initial begin
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      rot_count = '0;
      out_ready = 1'b1;

      // Reset state.
      tick();
      tick();
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_ring", ring3(out_a, out_b, out_c), ring3(2'd1, 2'd2, 2'd3));
      rst = 1'b1;
      tick();
      chk("post_rst_in_ready", in_ready, 1'b1);
      chk("post_rst_out_valid", out_valid, 1'b0);

      // Symbols 0,1,2 with two rotations.
      exp_q.push_back(pk(2'd0, 2'd1, 2'd2, 1'b0));
      exp_q.push_back(pk(2'd2, 2'd0, 2'd1, 1'b0));
      exp_q.push_back(pk(2'd1, 2'd2, 2'd0, 1'b1));
      send_frame(2'd0, 2'd1, 2'd2, 4'd2);
      chk("latency_out_valid", out_valid, 1'b1);
      chk("latency_busy", busy, 1'b1);
      chk("rotate_in_ready", in_ready, 1'b0);
      drain(1'b0, 1'b0);
      chk("frame_end_in_ready", in_ready, 1'b1);
      chk("frame_end_out_valid", out_valid, 1'b0);

      // rot_count = 0: single state, ring holds it afterwards.
      exp_q.push_back(pk(2'd3, 2'd0, 2'd1, 1'b1));
      send_frame(2'd3, 2'd0, 2'd1, 4'd0);
      chk("rc0_out_last", out_last, 1'b1);
      drain(1'b0, 1'b0);
      tick();
      chk("rc0_ring_hold", ring3(out_a, out_b, out_c), ring3(2'd3, 2'd0, 2'd1));
      chk("rc0_idle_out_valid", out_valid, 1'b0);

      // Back-pressure with out_ready toggling.
      exp_q.push_back(pk(2'd1, 2'd2, 2'd3, 1'b0));
      exp_q.push_back(pk(2'd3, 2'd1, 2'd2, 1'b0));
      exp_q.push_back(pk(2'd2, 2'd3, 2'd1, 1'b0));
      exp_q.push_back(pk(2'd1, 2'd2, 2'd3, 1'b1));
      send_frame(2'd1, 2'd2, 2'd3, 4'd3);
      drain(1'b1, 1'b0);

      // in_valid held high during ROTATE with changing in_data.
      send_frame(2'd1, 2'd2, 2'd3, 4'd2);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 2'(i);
         tick();
         chk("noisy_in_ready", in_ready, 1'b0);
         chk("noisy_ring", ring3(out_a, out_b, out_c), ring3(2'd1, 2'd2, 2'd3));
      end
      exp_q.push_back(pk(2'd1, 2'd2, 2'd3, 1'b0));
      exp_q.push_back(pk(2'd3, 2'd1, 2'd2, 1'b0));
      exp_q.push_back(pk(2'd2, 2'd3, 2'd1, 1'b1));
      out_ready = 1'b1;
      drain(1'b0, 1'b1);
      tick();
      chk("noisy_ring_final", ring3(out_a, out_b, out_c), ring3(2'd2, 2'd3, 2'd1));

      // Reset after the second output of an rot_count=5 frame.
      exp_q.push_back(pk(2'd0, 2'd1, 2'd2, 1'b0));
      exp_q.push_back(pk(2'd2, 2'd0, 2'd1, 1'b0));
      send_frame(2'd0, 2'd1, 2'd2, 4'd5);
      drain(1'b0, 1'b0);
      rst = 1'b0;
      tick();
      chk("midrot_rst_out_valid", out_valid, 1'b0);
      chk("midrot_rst_busy", busy, 1'b0);
      chk("midrot_rst_ring", ring3(out_a, out_b, out_c), ring3(2'd1, 2'd2, 2'd3));
      rst = 1'b1;
      tick();
      chk("midrot_rst_idle", out_valid, 1'b0);
      exp_q.push_back(pk(2'd3, 2'd3, 2'd0, 1'b0));
      exp_q.push_back(pk(2'd0, 2'd3, 2'd3, 1'b1));
      send_frame(2'd3, 2'd3, 2'd0, 4'd1);
      drain(1'b0, 1'b0);

      // Reset after one accepted symbol discards the partial frame.
      send_sym(2'd2, 4'd0);
      rst = 1'b0;
      tick();
      chk("midfill_rst_ring", ring3(out_a, out_b, out_c), ring3(2'd1, 2'd2, 2'd3));
      rst = 1'b1;
      tick();
      exp_q.push_back(pk(2'd0, 2'd0, 2'd0, 1'b1));
      send_frame(2'd0, 2'd0, 2'd0, 4'd0);
      drain(1'b0, 1'b0);

      // Partial frame held across a 10-cycle gap.
      send_sym(2'd2, 4'd0);
      send_sym(2'd1, 4'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("gap_out_valid", out_valid, 1'b0);
         chk("gap_ring", ring3(out_a, out_b, out_c), ring3(2'd2, 2'd1, 2'd0));
      end
      exp_q.push_back(pk(2'd2, 2'd1, 2'd3, 1'b0));
      exp_q.push_back(pk(2'd3, 2'd2, 2'd1, 1'b1));
      send_sym(2'd3, 4'd1);
      drain(1'b0, 1'b0);

      // Maximum rot_count: 16 states, no wrap of the remaining counter.
      push_rotations(2'd1, 2'd2, 2'd3, 15);
      send_frame(2'd1, 2'd2, 2'd3, 4'd15);
      drain(1'b0, 1'b0);
      tick();
      chk("max_rc_done_out_valid", out_valid, 1'b0);
      chk("max_rc_done_ring", ring3(out_a, out_b, out_c), ring3(2'd1, 2'd2, 2'd3));
      chk("queue_empty", exp_q.size(), 32'd0);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
